// File: rtl/div_unit_pkg.sv
// Shared constants, types and helpers for the multi-cycle DIV/DIVU unit.
// Encodings here are kept bit-compatible with the legacy defines header.
package div_unit_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int WORK_WIDTH = 2 * DATA_WIDTH + 1;
   localparam int CNT_WIDTH  = 6;

   localparam logic [CNT_WIDTH-1:0] DIV_ITERATIONS = CNT_WIDTH'(DATA_WIDTH);

   localparam logic [1:0] DIV_IDLE    = 2'b00;
   localparam logic [1:0] DIV_BY_ZERO = 2'b01;
   localparam logic [1:0] DIV_ON      = 2'b10;
   localparam logic [1:0] DIV_END     = 2'b11;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   localparam logic DIV_START = 1'b1;
   localparam logic DIV_STOP  = 1'b0;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef logic [WORK_WIDTH-1:0] div_work_t;

   // Per-operation context captured at start acceptance and used at completion.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] divisor_abs;
      logic                  q_neg;
      logic                  r_neg;
   } div_ctx_t;

   function automatic logic [DATA_WIDTH-1:0] abs_operand(
      input logic [DATA_WIDTH-1:0] value,
      input logic                  signed_op
   );
      return (signed_op && value[DATA_WIDTH-1]) ? (~value + 1'b1) : value;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] apply_sign(
      input logic [DATA_WIDTH-1:0] magnitude,
      input logic                  negate
   );
      return negate ? (~magnitude + 1'b1) : magnitude;
   endfunction

   function automatic logic is_div_aluop(input logic [7:0] aluop);
      return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Handshake and data bundle between the EX stage (master) and div_unit (slave).
interface div_unit_if;
   import div_unit_pkg::*;

   logic                    signed_div_in;
   logic [DATA_WIDTH-1:0]   dividend_in;
   logic [DATA_WIDTH-1:0]   divisor_in;
   logic                    start_in;
   logic                    annul_in;
   logic [2*DATA_WIDTH-1:0] result_out;
   logic                    ready_out;

   modport master (
      output signed_div_in,
      output dividend_in,
      output divisor_in,
      output start_in,
      output annul_in,
      input  result_out,
      input  ready_out
   );

   modport slave (
      input  signed_div_in,
      input  dividend_in,
      input  divisor_in,
      input  start_in,
      input  annul_in,
      output result_out,
      output ready_out
   );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial subtract of |divisor| from the upper
// window, then shift in the quotient bit.
module div_step
   import div_unit_pkg::*;
(
   input  div_work_t             work_in,
   input  logic [DATA_WIDTH-1:0] divisor_abs,
   output div_work_t             work_out
);

   logic [DATA_WIDTH:0] diff;
   logic                step_unused;

   // Bit 64 is the previous remainder MSB and is shifted out every iteration.
   assign step_unused = work_in[WORK_WIDTH-1];

   always_comb begin
      diff = {1'b0, work_in[2*DATA_WIDTH-1:DATA_WIDTH]} - {1'b0, divisor_abs};
      if (diff[DATA_WIDTH]) begin
         work_out = {work_in[2*DATA_WIDTH-1:0], 1'b0};
      end else begin
         work_out = {diff[DATA_WIDTH-1:0], work_in[DATA_WIDTH-1:0], 1'b1};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU; returns
// {remainder, quotient} for the HI/LO write path.
module div_unit
   import div_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   div_unit_if.slave  bus
);

   logic [1:0]              state;
   logic [CNT_WIDTH-1:0]    cnt;
   div_work_t               work;
   div_work_t               work_next;
   div_ctx_t                ctx;
   logic [2*DATA_WIDTH-1:0] result;
   logic                    ready;

   logic                    start_req;
   logic [DATA_WIDTH-1:0]   dividend_abs;
   logic [DATA_WIDTH-1:0]   divisor_abs_in;
   logic [DATA_WIDTH-1:0]   quotient;
   logic [DATA_WIDTH-1:0]   remainder;

   assign start_req      = (bus.start_in == DIV_START) && !bus.annul_in;
   assign dividend_abs   = abs_operand(bus.dividend_in, bus.signed_div_in);
   assign divisor_abs_in = abs_operand(bus.divisor_in, bus.signed_div_in);

   // Final sign fix-up; negation wraps mod 2^32 so 0x80000000 / -1 stays 0x80000000.
   assign quotient  = apply_sign(work[DATA_WIDTH-1:0], ctx.q_neg);
   assign remainder = apply_sign(work[WORK_WIDTH-1:DATA_WIDTH+1], ctx.r_neg);

   div_step u_step (
      .work_in     (work),
      .divisor_abs (ctx.divisor_abs),
      .work_out    (work_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= DIV_IDLE;
         cnt    <= '0;
         work   <= '0;
         ctx    <= '0;
         result <= '0;
         ready  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_req) begin
                  if (bus.divisor_in == '0) begin
                     state <= DIV_BY_ZERO;
                  end else begin
                     state           <= DIV_ON;
                     work            <= {{DATA_WIDTH{1'b0}}, dividend_abs, 1'b0};
                     cnt             <= '0;
                     ctx.divisor_abs <= divisor_abs_in;
                     ctx.q_neg       <= bus.signed_div_in &
                                        (bus.dividend_in[DATA_WIDTH-1] ^ bus.divisor_in[DATA_WIDTH-1]);
                     ctx.r_neg       <= bus.signed_div_in & bus.dividend_in[DATA_WIDTH-1];
                  end
               end
            end

            DIV_BY_ZERO: begin
               if (bus.annul_in) begin
                  state <= DIV_IDLE;
               end else begin
                  state  <= DIV_END;
                  result <= '0;
                  ready  <= DIV_RESULT_READY;
               end
            end

            DIV_ON: begin
               if (bus.annul_in) begin
                  state <= DIV_IDLE;
                  cnt   <= '0;
                  work  <= '0;
               end else if (cnt == DIV_ITERATIONS) begin
                  state  <= DIV_END;
                  result <= {remainder, quotient};
                  ready  <= DIV_RESULT_READY;
               end else begin
                  work <= work_next;
                  cnt  <= cnt + 1'b1;
               end
            end

            DIV_END: begin
               // Result is held until EX drops start, which acknowledges consumption.
               if (bus.annul_in || (bus.start_in == DIV_STOP)) begin
                  state  <= DIV_IDLE;
                  result <= '0;
                  ready  <= DIV_RESULT_NOT_READY;
               end
            end

            default: begin
               state  <= DIV_IDLE;
               result <= '0;
               ready  <= DIV_RESULT_NOT_READY;
            end
         endcase
      end
   end

   assign bus.result_out = result;
   assign bus.ready_out  = ready;

endmodule
